// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the display scheduler and its scan timer.
package display_pkg;

  // FSM states
  typedef enum logic [1:0] {
    ST_SHOW_TIME  = 2'd0,
    ST_SHOW_ALARM = 2'd1,
    ST_EDIT_HI    = 2'd2,
    ST_EDIT_LO    = 2'd3
  } state_e;

  // edit_field codes reported to the time-set logic
  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_LO   = 2'd1;
  localparam logic [1:0] EDIT_HI   = 2'd2;

  // Digit enable masks (bit i = digit i, 1 = lit)
  localparam logic [3:0] MASK_ALL    = 4'b1111;
  localparam logic [3:0] MASK_LO_OFF = 4'b1100;
  localparam logic [3:0] MASK_HI_OFF = 4'b0011;

endpackage

// File: rtl/display_scheduler_scan_timer.sv
// Free-running scan sequencer: prescaler, 8-phase byte_status and frame pulse.
module display_scan_timer #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] byte_status,
  output logic       frame_tick
);
  import display_pkg::*;

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_phase;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap      = (r_presc == PW'(SCAN_DIV - 1));
  assign byte_status = r_phase;
  assign frame_tick  = r_tick;

  // Prescaler and phase counter; the tick marks the cycle where the phase wraps 7->0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_phase <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) r_phase <= r_phase + 3'd1;
      r_tick  <= w_wrap && (r_phase == 3'd7);
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Display mode FSM: picks time or alarm for the driver and blinks the field in edit.
module display_scheduler #(
  parameter int SCAN_DIV          = 1000,
  parameter int BLINK_FRAMES      = 64,
  parameter int ALARM_HOLD_FRAMES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] time_value,
  input  logic [11:0] alarm_value,
  input  logic        btn_mode,
  input  logic        btn_alarm,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic [3:0]  segment_byte_control,
  output logic [1:0]  edit_field,
  output logic        frame_tick
);
  import display_pkg::*;

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int HW = $clog2(ALARM_HOLD_FRAMES + 1);

  state_e        r_state, w_state_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic          r_blink, w_blink_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [11:0]   r_data, w_data_nxt;
  logic [3:0]    r_mask, w_mask_nxt;
  logic [1:0]    r_edit, w_edit_nxt;
  logic          w_tick;

  display_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clock       (clock),
    .reset       (reset),
    .byte_status (byte_status),
    .frame_tick  (w_tick)
  );

  assign frame_tick           = w_tick;
  assign data_show            = r_data;
  assign segment_byte_control = r_mask;
  assign edit_field           = r_edit;

  // State, blink and hold registers plus registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SHOW_TIME;
      r_bcnt  <= '0;
      r_blink <= 1'b1;
      r_hold  <= '0;
      r_data  <= '0;
      r_mask  <= MASK_ALL;
      r_edit  <= EDIT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_blink <= w_blink_nxt;
      r_hold  <= w_hold_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
      r_edit  <= w_edit_nxt;
    end
  end

  // Next state; btn_mode has priority over btn_alarm
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_SHOW_TIME: begin
        if (btn_mode) w_state_nxt = ST_EDIT_HI;
        else if (btn_alarm) begin
          w_state_nxt = ST_SHOW_ALARM;
          w_hold_nxt  = '0;
        end
      end
      ST_SHOW_ALARM: begin
        if (btn_mode) w_state_nxt = ST_SHOW_TIME;
        else if (btn_alarm) w_hold_nxt = '0;
        else if (w_tick) begin
          if (r_hold == HW'(ALARM_HOLD_FRAMES - 1)) w_state_nxt = ST_SHOW_TIME;
          else w_hold_nxt = r_hold + 1'b1;
        end
      end
      ST_EDIT_HI: if (btn_mode) w_state_nxt = ST_EDIT_LO;
      ST_EDIT_LO: if (btn_mode) w_state_nxt = ST_SHOW_TIME;
      default:    w_state_nxt = ST_SHOW_TIME;
    endcase
  end

  // Blink timing restarts visible on every state change so the new field shows at once
  always_comb begin
    w_bcnt_nxt  = r_bcnt;
    w_blink_nxt = r_blink;
    if (w_state_nxt != r_state) begin
      w_bcnt_nxt  = '0;
      w_blink_nxt = 1'b1;
    end else if (w_tick) begin
      if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
        w_bcnt_nxt  = '0;
        w_blink_nxt = ~r_blink;
      end else begin
        w_bcnt_nxt = r_bcnt + 1'b1;
      end
    end
  end

  // Output decode from next state so outputs move together with the state register
  always_comb begin
    w_data_nxt = (w_state_nxt == ST_SHOW_ALARM) ? alarm_value : time_value;
    w_mask_nxt = MASK_ALL;
    w_edit_nxt = EDIT_NONE;
    case (w_state_nxt)
      ST_EDIT_HI: begin
        w_mask_nxt = w_blink_nxt ? MASK_ALL : MASK_HI_OFF;
        w_edit_nxt = EDIT_HI;
      end
      ST_EDIT_LO: begin
        w_mask_nxt = w_blink_nxt ? MASK_ALL : MASK_LO_OFF;
        w_edit_nxt = EDIT_LO;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequences the four-digit seven-segment driver of the clock.
- Generates the scan phase `byte_status` and selects which 12-bit value is shown: current time or alarm setting.
- Produces `segment_byte_control` digit enables so the field being edited blinks.
- Sits between the timekeeping/alarm registers and the segment driver; also tells the time-set logic which field is in edit.

Parameters:
- SCAN_DIV, 1000, clock cycles per scan phase (≥2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1).
- ALARM_HOLD_FRAMES, 256, frames the alarm preview stays up before auto-return (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- time_value  in  12  {hi[11:6], lo[5:0]} current time fields.
- alarm_value  in  12  {hi, lo} alarm setting.
- btn_mode  in  1  single-cycle pulse, debounced upstream.
- btn_alarm  in  1  single-cycle pulse, debounced upstream.
- data_show  out  12  value routed to the segment driver.
- byte_status  out  3  scan phase 0..7.
- segment_byte_control  out  4  digit enables; bit i = digit i, 1 = lit.
- edit_field  out  2  0 = none, 1 = lo field, 2 = hi field.
- frame_tick  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Reset is one clock, asynchronous, active-low. While reset is low: byte_status=0, prescaler=0, frame_tick=0, data_show=0, segment_byte_control=4'b1111, edit_field=0, state=SHOW_TIME, blink_phase=1, hold counter=0. Reset mid-operation aborts any edit or preview immediately.
- Scan timing:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, byte_status increments modulo 8.
  - Phases 0/2/4/6 drive digits 0..3. Odd phases are blanking gaps handled by the driver.
  - frame_tick is high for the single cycle in which byte_status wraps 7→0.
- Blink:
  - A frame counter 0..BLINK_FRAMES-1 advances on frame_tick; blink_phase toggles on its wrap.
  - Any state change reloads the frame counter to 0 and blink_phase to 1, so the new field is visible immediately.
- FSM states: SHOW_TIME, SHOW_ALARM, EDIT_HI, EDIT_LO.
  - SHOW_TIME:
    - btn_mode → EDIT_HI.
    - else btn_alarm → SHOW_ALARM, hold counter cleared.
  - SHOW_ALARM:
    - btn_mode → SHOW_TIME.
    - btn_alarm clears the hold counter (restart).
    - hold counter increments on frame_tick; reaching ALARM_HOLD_FRAMES → SHOW_TIME.
  - EDIT_HI: btn_mode → EDIT_LO; btn_alarm ignored.
  - EDIT_LO: btn_mode → SHOW_TIME; btn_alarm ignored.
  - btn_mode and btn_alarm in the same cycle: btn_mode wins.
- Outputs are registered. They reflect a state change one cycle after the button pulse is sampled.
  - data_show = alarm_value in SHOW_ALARM, otherwise time_value. Tracks input changes with 1-cycle latency.
  - segment_byte_control:
    - 4'b1111 in SHOW_TIME and SHOW_ALARM.
    - EDIT_HI: {blink_phase?2'b11:2'b00, 2'b11}.
    - EDIT_LO: {2'b11, blink_phase?2'b11:2'b00}.
  - edit_field = 2 in EDIT_HI, 1 in EDIT_LO, else 0.
- Field values are passed unmodified; out-of-range values (e.g. >59) are the driver's concern.
- The scan counter runs free regardless of FSM state. Button events never reset the scan counter.

Decomposition:
- Shared package display_pkg:
  - FSM state encoding.
  - edit_field codes (EDIT_NONE, EDIT_LO, EDIT_HI).
  - Digit mask constants (MASK_ALL=4'b1111, MASK_LO_OFF=4'b1100, MASK_HI_OFF=4'b0011).
- One sub-module, display_scan_timer: prescaler, byte_status counter and frame_tick, parameterised by SCAN_DIV.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, ALARM_HOLD_FRAMES=3):
- Reset release, no buttons → byte_status steps 0→1 after 4 clocks; frame_tick one cycle high at clock 32, then every 32 clocks; segment_byte_control=1111.
- time_value={6'd12,6'd34}, idle → data_show={6'd12,6'd34} one cycle later; changing time_value to {6'd12,6'd35} appears on data_show next cycle.
- Alarm preview:
  - btn_alarm pulse with alarm_value={6'd7,6'd30} → data_show={7,30} next cycle.
  - After the 3rd frame_tick, data_show returns to time_value.
  - A second btn_alarm after 2 frames extends the preview to 3 frames from that pulse.
- Edit sequence:
  - btn_mode → edit_field=2; mask 1111 for 2 frames, then 0011 for 2 frames, repeating.
  - btn_mode → edit_field=1; mask restarts at 1111, then 1100.
  - btn_mode → SHOW_TIME, edit_field=0, mask 1111.
- btn_mode and btn_alarm same cycle in SHOW_TIME → EDIT_HI (edit_field=2), data_show remains time_value; btn_alarm in EDIT_HI has no effect.
- Reset pulsed low in EDIT_LO mid-frame (byte_status=5) → all outputs take reset values asynchronously; after release, state SHOW_TIME and scan restarts from 0.
